// File: rtl/array_scan_pkg.sv
// Shared types and helpers for the array scan engine.
package array_scan_pkg;

  typedef enum logic [2:0] {
    OP_INDEX_LAST    = 3'd0,
    OP_INDEX_FIRST   = 3'd1,
    OP_COUNT_LESS    = 3'd2,
    OP_COUNT_GREATER = 3'd3,
    OP_COUNT_EQUAL   = 3'd4
  } scan_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } scan_state_e;

  localparam logic [2:0] OP_LAST_LEGAL = 3'd4;

  // Width of an index/count that must hold 0..narea.
  function automatic int res_width(input int narea);
    return $clog2(narea + 1);
  endfunction

endpackage

// File: rtl/array_scan_lanes.sv
// Combinational per-beat matcher: match count plus first/last matching lane.
module array_scan_lanes
  import array_scan_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int LANES = 2,
  parameter int LCW   = $clog2(LANES + 1),
  parameter int LIW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic [LANES-1:0]       i_mask,
  input  logic [WIDTH-1:0]       i_key,
  input  scan_op_e               i_op,
  output logic [LCW-1:0]         o_count,
  output logic                   o_first_vld,
  output logic [LIW-1:0]         o_first_lane,
  output logic                   o_last_vld,
  output logic [LIW-1:0]         o_last_lane
);

  logic [LANES-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int l = 0; l < LANES; l++) begin
      case (i_op)
        OP_COUNT_LESS:    w_match[l] = i_mask[l] && (i_data[l*WIDTH +: WIDTH] < i_key);
        OP_COUNT_GREATER: w_match[l] = i_mask[l] && (i_data[l*WIDTH +: WIDTH] > i_key);
        default:          w_match[l] = i_mask[l] && (i_data[l*WIDTH +: WIDTH] == i_key);
      endcase
    end
  end

  always_comb begin
    o_count      = '0;
    o_first_vld  = 1'b0;
    o_first_lane = '0;
    o_last_vld   = 1'b0;
    o_last_lane  = '0;
    // Walk downwards so the lowest matching lane is the one left standing.
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_match[l]) begin
        o_first_vld  = 1'b1;
        o_first_lane = LIW'(l);
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (w_match[l]) begin
        o_count     = o_count + LCW'(1);
        o_last_vld  = 1'b1;
        o_last_lane = LIW'(l);
      end
    end
  end

endmodule

// File: rtl/array_scan_engine.sv
// Sequential array scan engine: index search or key-compare count over one heap area.
// Optional build macro ARRAY_SCAN_EARLY_EXIT_EN lets INDEX_FIRST stop at the first matching beat.
//
// state | meaning
// IDLE  | waiting for start, result held
// ISSUE | one heap beat read per cycle, previous beat accumulated
// DRAIN | accumulate the final beat
// FIN   | done pulse, result valid
module array_scan_engine
  import array_scan_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NAREA = 10,
  parameter int LANES = 2,
  parameter int AW    = 14,
  parameter int NW    = 11
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   op,
  input  logic [NW-1:0]                array,
  input  logic [res_width(NAREA)-1:0]  size,
  input  logic [WIDTH-1:0]             key,
  output logic                         busy,
  output logic                         rd_en,
  output logic [AW-1:0]                rd_addr,
  input  logic [LANES*WIDTH-1:0]       rd_data,
  output logic                         done,
  output logic [res_width(NAREA)-1:0]  result,
  output logic                         error
);

  localparam int RW  = res_width(NAREA);
  localparam int BPA = NAREA / LANES;
  localparam int LCW = $clog2(LANES + 1);
  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

  scan_state_e      r_state, w_state_next;
  scan_op_e         r_op;
  logic [WIDTH-1:0] r_key;
  logic [RW-1:0]    r_n, r_left, r_issue_base, r_pend_base, r_acc, r_result;
  logic [AW-1:0]    r_addr;
  logic             r_pend, r_found, r_error;

  logic             w_illegal, w_last_beat, w_exit, w_to_fin, w_found_next;
  logic [RW-1:0]    w_n, w_acc_next;
  logic [AW-1:0]    w_base;
  logic [LANES-1:0] w_mask;
  logic [LCW-1:0]   w_cnt;
  logic             w_first_vld, w_last_vld;
  logic [LIW-1:0]   w_first_lane, w_last_lane;

  assign w_n         = (size > RW'(NAREA)) ? RW'(NAREA) : size;
  assign w_illegal   = (op > OP_LAST_LEGAL);
  assign w_base      = AW'(array) * AW'(BPA);
  // r_left counts elements still to be issued; the beat that covers the rest is the last.
  assign w_last_beat = (r_left <= RW'(LANES));
  assign w_to_fin    = (w_state_next == ST_FIN) && (r_state != ST_FIN);

  assign rd_addr = r_addr;
  assign result  = r_result;

  always_comb begin
    w_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      w_mask[l] = r_pend && ((r_pend_base + RW'(l)) < r_n);
    end
  end

  array_scan_lanes #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .LCW   (LCW),
    .LIW   (LIW)
  ) u_lanes (
    .i_data       (rd_data),
    .i_mask       (w_mask),
    .i_key        (r_key),
    .i_op         (r_op),
    .o_count      (w_cnt),
    .o_first_vld  (w_first_vld),
    .o_first_lane (w_first_lane),
    .o_last_vld   (w_last_vld),
    .o_last_lane  (w_last_lane)
  );

  always_comb begin
    w_acc_next   = r_acc;
    w_found_next = r_found;
    if (r_pend) begin
      case (r_op)
        OP_INDEX_LAST: begin
          if (w_last_vld) w_acc_next = r_pend_base + RW'(w_last_lane) + RW'(1);
        end
        OP_INDEX_FIRST: begin
          if (w_first_vld && !r_found) begin
            w_acc_next   = r_pend_base + RW'(w_first_lane) + RW'(1);
            w_found_next = 1'b1;
          end
        end
        default: w_acc_next = r_acc + RW'(w_cnt);
      endcase
    end
  end

`ifdef ARRAY_SCAN_EARLY_EXIT_EN
  // A beat issued in the exit cycle is left in flight and never accumulated.
  assign w_exit = r_pend && (r_op == OP_INDEX_FIRST) && w_first_vld;
`else
  assign w_exit = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    rd_en        = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = ((w_n == '0) || w_illegal) ? ST_FIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (w_exit)           w_state_next = ST_FIN;
        else if (w_last_beat) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: w_state_next = ST_FIN;
      ST_FIN: begin
        done         = 1'b1;
        error        = r_error;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op         <= OP_INDEX_LAST;
      r_key        <= '0;
      r_n          <= '0;
      r_left       <= '0;
      r_issue_base <= '0;
      r_pend_base  <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_addr       <= '0;
      r_pend       <= 1'b0;
      r_found      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_pend      <= rd_en;
      r_pend_base <= r_issue_base;
      if (w_to_fin) r_result <= (r_state == ST_IDLE) ? '0 : w_acc_next;
      if (r_state == ST_IDLE && start) begin
        r_op         <= scan_op_e'(op);
        r_key        <= key;
        r_n          <= w_n;
        r_left       <= w_n;
        r_issue_base <= '0;
        r_addr       <= w_base;
        r_acc        <= '0;
        r_found      <= 1'b0;
        r_error      <= w_illegal;
      end else begin
        r_acc   <= w_acc_next;
        r_found <= w_found_next;
        if (rd_en) begin
          r_left       <= r_left - RW'(LANES);
          r_issue_base <= r_issue_base + RW'(LANES);
          r_addr       <= r_addr + AW'(1);
        end
      end
    end
  end

endmodule
